jtexterm_objmix: RTL and testbench

//  Sprite line buffer and sprite/tile priority mixer, directly upstream of the palette stage.
//  The sprite drawer writes pixels into one bank while the other bank is scanned out on the current line.

---
 rtl/jtexterm_pkg.sv | 16 +
 rtl/jtexterm_objmix_dual_ram.sv | 36 +++
 rtl/jtexterm_objmix.sv | 146 ++++++++++++++
 tb/tb_jtexterm_objmix.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtexterm_pkg.sv
// Shared constants and FSM encoding for the sprite line buffer / mixer.
package jtexterm_pkg;

  localparam int unsigned PW_DFLT = 9;
  localparam int unsigned XW_DFLT = 9;

  // Colour nibble treated as transparent; an all-ones word is the erase/init fill.
  localparam logic [3:0]         TRANSP = 4'hF;
  localparam logic [PW_DFLT-1:0] FILL   = {PW_DFLT{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/jtexterm_objmix_dual_ram.sv
// Dual-port line buffer RAM, single clock.
//  Port 0: write only (sprite drawer).
//  Port 1: registered read plus write (scan read, erase, init fill).
// Ports: clk, rst_n, i_we0/i_addr0/i_data0, i_we1/i_addr1/i_data1, o_q1.
module jtframe_dual_ram #(
  parameter int unsigned aw = 10,
  parameter int unsigned dw = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we0,
  input  logic [aw-1:0] i_addr0,
  input  logic [dw-1:0] i_data0,
  input  logic          i_we1,
  input  logic [aw-1:0] i_addr1,
  input  logic [dw-1:0] i_data1,
  output logic [dw-1:0] o_q1
);

  localparam int unsigned DEPTH = 2**aw;

  logic [dw-1:0] r_mem [DEPTH];

  // Storage; port 1 takes precedence on an address clash.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_addr0] <= i_data0;
    if (i_we1) r_mem[i_addr1] <= i_data1;
  end

  // Read-first registered output for port 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_q1 <= '0;
    else        o_q1 <= r_mem[i_addr1];
  end

endmodule

// File: rtl/jtexterm_objmix.sv
// Sprite line buffer and sprite/tile priority mixer feeding the palette stage.
// The drawer fills one bank while the other is scanned and erased behind the read.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  pxl_cen               pixel clock enable (at most one pulse every 2 clk)
//  LHBL, LVBL            horizontal / vertical blank, active low
//  hdump, tile_pxl       scan position and tile pixel for that position
//  obj_we, obj_x, obj_pxl drawer write port
//  init_done             both banks cleared after reset
//  col_addr              mixed pixel to palette RAM
module jtexterm_objmix #(
  parameter int unsigned PW     = 9,
  parameter int unsigned XW     = 9,
  parameter logic [3:0]  TRANSP = jtexterm_pkg::TRANSP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [XW-1:0] hdump,
  input  logic [PW-1:0] tile_pxl,
  input  logic          obj_we,
  input  logic [XW-1:0] obj_x,
  input  logic [PW-1:0] obj_pxl,
  output logic          init_done,
  output logic [PW-1:0] col_addr
);
  import jtexterm_pkg::*;

  localparam int unsigned   AW       = XW + 1;
  localparam logic [AW-1:0] CLR_LAST = {AW{1'b1}};
  localparam logic [PW-1:0] L_FILL   = {PW{1'b1}};

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_clr_cnt;
  logic          r_bank, r_lhbl_l, r_erase;
  logic [AW-1:0] r_rd_addr;
  logic [PW-1:0] r_tile_l, r_obj_l;
  logic          w_run, w_scan, w_swap;

  logic          w_we0, w_we1;
  logic [AW-1:0] w_addr0, w_addr1;
  logic [PW-1:0] w_data1, w_q1;

  assign w_run  = (r_state == ST_RUN);
  assign w_scan = w_run & pxl_cen & LHBL;
  assign w_swap = w_run & r_lhbl_l & ~LHBL;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nx;
  end

  // FSM next state
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_INIT: if (r_clr_cnt == CLR_LAST) w_state_nx = ST_RUN;
      ST_RUN:  w_state_nx = ST_RUN;
      default: w_state_nx = ST_INIT;
    endcase
  end

  // Clear counter and init flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      if (!w_run) r_clr_cnt <= r_clr_cnt + AW'(1);
      init_done <= (w_state_nx == ST_RUN);
    end
  end

  // Blank edge detect and bank swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lhbl_l <= 1'b0;
      r_bank   <= 1'b0;
    end else begin
      r_lhbl_l <= LHBL;
      if (w_swap) r_bank <= ~r_bank;
    end
  end

  // Scan pipeline: latch address/tile on the read, sprite data one clk later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_tile_l  <= '0;
      r_obj_l   <= '0;
      r_erase   <= 1'b0;
    end else begin
      r_erase <= w_scan;
      if (w_scan) begin
        r_rd_addr <= {r_bank, hdump};
        r_tile_l  <= tile_pxl;
      end
      if (r_erase) r_obj_l <= w_q1;
    end
  end

  // Priority mix, blanked to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_addr <= '0;
    end else if (w_run && pxl_cen) begin
      if (!LHBL || !LVBL)              col_addr <= '0;
      else if (r_obj_l[3:0] != TRANSP) col_addr <= r_obj_l;
      else                             col_addr <= r_tile_l;
    end
  end

  // Draw port into the bank not being scanned
  assign w_we0   = w_run & obj_we & (obj_pxl[3:0] != TRANSP);
  assign w_addr0 = {~r_bank, obj_x};

  // Scan-side port: init fill, else erase behind the read, else scan read
  always_comb begin
    w_we1   = 1'b0;
    w_addr1 = {r_bank, hdump};
    w_data1 = L_FILL;
    if (!w_run) begin
      w_we1   = 1'b1;
      w_addr1 = r_clr_cnt;
    end else if (r_erase) begin
      w_we1   = 1'b1;
      w_addr1 = r_rd_addr;
    end
  end

  jtframe_dual_ram #(.aw(AW), .dw(PW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we0   (w_we0),
    .i_addr0 (w_addr0),
    .i_data0 (obj_pxl),
    .i_we1   (w_we1),
    .i_addr1 (w_addr1),
    .i_data1 (w_data1),
    .o_q1    (w_q1)
  );

endmodule

// File: tb/tb_jtexterm_objmix.sv
// Self-checking bench for jtexterm_objmix.
module tb_jtexterm_objmix;

  localparam int HACT = 40;
  localparam int NBL  = 4;
  localparam logic [8:0] FILLV = 9'h1FF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b1;
  logic [8:0] hdump = '0;
  logic [8:0] tile_pxl = '0;
  logic       obj_we = 1'b0;
  logic [8:0] obj_x = '0;
  logic [8:0] obj_pxl = '0;
  logic       init_done;
  logic [8:0] col_addr;

  int total = 0;
  int bad   = 0;

  // Reference model: two banks of pixels, current scan bank, pending mix result.
  logic [8:0] m_mem [2][512];
  int         m_bank;
  bit         m_run, m_lhbl_l, m_pv, m_known, m_done;
  int         m_cnt;
  logic [8:0] m_col, m_pend;

  logic [8:0] obs [64];
  logic [8:0] tl  [64];

  jtexterm_objmix dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .hdump     (hdump),
    .tile_pxl  (tile_pxl),
    .obj_we    (obj_we),
    .obj_x     (obj_x),
    .obj_pxl   (obj_pxl),
    .init_done (init_done),
    .col_addr  (col_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] mix(input logic [8:0] o, input logic [8:0] t);
    return (o[3:0] != 4'hF) ? o : t;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) m_mem[b][a] = FILLV;
    m_bank = 0; m_run = 0; m_lhbl_l = 0; m_pv = 0;
    m_known = 1; m_col = '0; m_pend = '0; m_done = 0; m_cnt = 0;
  endtask

  // Apply the model for the coming clock edge, clock once, then compare.
  task automatic step();
    if (rst_n) begin
      if (!m_run) begin
        m_cnt++;
        if (m_cnt == 1024) begin m_run = 1; m_done = 1; end
      end else begin
        if (obj_we && obj_pxl[3:0] != 4'hF) m_mem[1-m_bank][obj_x] = obj_pxl;
        if (pxl_cen) begin
          if (!LHBL || !LVBL) begin m_col = '0; m_known = 1; end
          else if (m_pv)      begin m_col = m_pend; m_known = 1; end
          else                m_known = 0;
          if (LHBL) begin
            m_pend = mix(m_mem[m_bank][hdump], tile_pxl);
            m_mem[m_bank][hdump] = FILLV;
            m_pv = 1;
          end
        end
        if (m_lhbl_l && !LHBL) m_bank = 1 - m_bank;
      end
      m_lhbl_l = LHBL;
    end
    @(posedge clk); #1;
    total++;
    if (init_done !== m_done) begin
      bad++;
      $display("FAIL init_done t=%0t got=%b exp=%b", $time, init_done, m_done);
    end
    if (m_known) begin
      total++;
      if (col_addr !== m_col) begin
        bad++;
        $display("FAIL col_addr t=%0t got=%h exp=%h", $time, col_addr, m_col);
      end
    end
  endtask

  task automatic rnd_draw(input bit en);
    obj_we = en;
    if (en) begin
      obj_x = 9'($urandom_range(0, HACT));
      if ($urandom_range(0, 3) == 0) obj_pxl = {5'($urandom), 4'hF};
      else                           obj_pxl = 9'($urandom);
    end
  endtask

  task automatic draw(input logic [8:0] x, input logic [8:0] p);
    obj_we = 1'b1; obj_x = x; obj_pxl = p;
    step();
    obj_we = 1'b0;
  endtask

  // One line: active pixels 0..n, then blanking (swap on LHBL fall).
  task automatic scan_line(input bit rnd_tile, input logic [8:0] tconst, input int n,
                           input bit fast, input bit lvbl, input bit drw);
    LVBL = lvbl;
    for (int h = 0; h <= n; h++) begin
      LHBL = 1'b1;
      hdump = 9'(h);
      tile_pxl = rnd_tile ? 9'($urandom) : tconst;
      tl[h] = tile_pxl;
      pxl_cen = 1'b1;
      rnd_draw(drw);
      step();
      if (h > 0) obs[h-1] = col_addr;
      pxl_cen = 1'b0;
      if (fast && h == n) LHBL = 1'b0;
      rnd_draw(drw);
      step();
    end
    LHBL = 1'b0;
    obj_we = 1'b0;
    for (int b = 0; b < NBL; b++) begin
      hdump = 9'(n + 1 + b);
      pxl_cen = 1'b1; step();
      pxl_cen = 1'b0; step();
    end
    LVBL = 1'b1;
  endtask

  task automatic check_obs_tile(input string nm, input int n);
    for (int h = 0; h < n; h++) begin
      total++;
      if (obs[h] !== tl[h]) begin
        bad++;
        $display("FAIL %s h=%0d got=%h exp=%h", nm, h, obs[h], tl[h]);
      end
    end
  endtask

  task automatic init_wait(input string nm);
    LHBL = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      pxl_cen = (i % 2 == 1);
      tile_pxl = 9'($urandom);
      step();
    end
    pxl_cen = 1'b0;
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL %s_early got=%b exp=0", nm, init_done);
    end
    step();
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL %s_1024 got=%b exp=1", nm, init_done);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if (col_addr !== 9'h000 || init_done !== 1'b0) begin
      bad++; $display("FAIL reset_vals got=%h/%b exp=000/0", col_addr, init_done);
    end
    rst_n = 1'b1;
    init_wait("init");
  endtask

  task automatic test_first_line();
    scan_line(1'b1, 9'h0, HACT, 1'b0, 1'b1, 1'b0);
    check_obs_tile("first_line", HACT);
  endtask

  task automatic test_draw_mix();
    draw(9'd10, 9'h123);
    scan_line(1'b0, 9'h0A5, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b0, 9'h0A5, HACT, 1'b0, 1'b1, 1'b0);
    for (int h = 0; h < HACT; h++) begin
      total++;
      if (obs[h] !== ((h == 10) ? 9'h123 : 9'h0A5)) begin
        bad++; $display("FAIL draw_mix h=%0d got=%h", h, obs[h]);
      end
    end
    scan_line(1'b0, 9'h0A5, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b0, 9'h0A5, HACT, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs[10] !== 9'h0A5) begin
      bad++; $display("FAIL erased_x10 got=%h exp=0a5", obs[10]);
    end
  endtask

  task automatic test_transp();
    draw(9'd20, 9'h05F);
    draw(9'd20, 9'h041);
    draw(9'd20, 9'h082);
    draw(9'd21, 9'h041);
    draw(9'd21, 9'h1BF);
    scan_line(1'b0, 9'h033, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b0, 9'h033, HACT, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs[20] !== 9'h082) begin
      bad++; $display("FAIL last_wins got=%h exp=082", obs[20]);
    end
    total++;
    if (obs[21] !== 9'h041) begin
      bad++; $display("FAIL transp_drop got=%h exp=041", obs[21]);
    end
  endtask

  task automatic test_back_to_back();
    scan_line(1'b1, 9'h0, HACT - 8, 1'b1, 1'b1, 1'b1);
    scan_line(1'b1, 9'h0, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b1, 9'h0, HACT, 1'b0, 1'b1, 1'b0);
    check_obs_tile("old_bank_erased", HACT);
  endtask

  task automatic test_vblank();
    draw(9'd5, 9'h0C3);
    scan_line(1'b0, 9'h011, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b0, 9'h011, HACT, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < HACT; h++) begin
      total++;
      if (obs[h] !== 9'h000) begin
        bad++; $display("FAIL vblank_zero h=%0d got=%h exp=000", h, obs[h]);
      end
    end
    scan_line(1'b0, 9'h011, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b0, 9'h011, HACT, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs[5] !== 9'h011) begin
      bad++; $display("FAIL vblank_erase got=%h exp=011", obs[5]);
    end
  endtask

  task automatic test_reset_midline();
    draw(9'd3, 9'h1C4);
    scan_line(1'b0, 9'h0A5, HACT, 1'b0, 1'b1, 1'b0);
    LHBL = 1'b1; LVBL = 1'b1;
    for (int h = 0; h < 8; h++) begin
      hdump = 9'(h); tile_pxl = 9'h0A5;
      pxl_cen = 1'b1; step();
      pxl_cen = 1'b0; step();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (col_addr !== 9'h000 || init_done !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%b exp=000/0", col_addr, init_done);
    end
    repeat (2) step();
    rst_n = 1'b1;
    init_wait("reinit");
    scan_line(1'b1, 9'h0, HACT, 1'b0, 1'b1, 1'b0);
    check_obs_tile("post_reset_line", HACT);
    draw(9'd7, 9'h1A2);
    scan_line(1'b1, 9'h0, HACT, 1'b0, 1'b1, 1'b0);
    scan_line(1'b1, 9'h0, HACT, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs[7] !== 9'h1A2) begin
      bad++; $display("FAIL post_reset_mix got=%h exp=1a2", obs[7]);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_draw_mix();
    test_transp();
    test_back_to_back();
    test_vblank();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
